// File: rtl/adder_pkg.sv
// Shared constants and types for the 16-bit carry-lookahead adder.
package adder_pkg;

    localparam int unsigned ADD_W  = 16;
    localparam int unsigned GRP_W  = 4;
    localparam int unsigned GRP_N  = ADD_W / GRP_W;
    localparam int unsigned SUM_W  = ADD_W + 1;

    // Group generate / propagate pair produced by each 4-bit CLA group.
    typedef struct packed {
        logic g;
        logic p;
    } group_gp_t;

endpackage : adder_pkg

// File: rtl/cla4_group.sv
// 4-bit carry-lookahead group: local sums plus group generate/propagate.
module cla4_group
    import adder_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             cin,
    output logic [GRP_W-1:0] s,
    output logic             g_grp,
    output logic             p_grp
);

    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] p;
    logic [GRP_W-1:0] c;

    // Bit-level generate/propagate, in-group lookahead carries and sums.
    always_comb begin
        g = a & b;
        p = a ^ b;

        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);

        s = p ^ c;

        g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        p_grp = &p;
    end

endmodule : cla4_group

// File: rtl/bit16_adder.sv
// 16-bit two-level carry-lookahead adder with a registered 17-bit result.
module bit16_adder
    import adder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ADD_W-1:0] in1,
    input  logic [ADD_W-1:0] in2,
    input  logic             cy_in,
    output logic             cy_out,
    output logic [SUM_W-1:0] sum
);

    group_gp_t        gp [GRP_N];
    logic [GRP_N:0]   gc;
    logic [ADD_W-1:0] s_c;

    // Four CLA groups; each takes its carry from the lookahead unit, never from a neighbour.
    for (genvar i = 0; i < int'(GRP_N); i++) begin : g_grp
        cla4_group u_grp (
            .a     (in1[i*GRP_W +: GRP_W]),
            .b     (in2[i*GRP_W +: GRP_W]),
            .cin   (gc[i]),
            .s     (s_c[i*GRP_W +: GRP_W]),
            .g_grp (gp[i].g),
            .p_grp (gp[i].p)
        );
    end

    // Second-level lookahead: group carries in flat sum-of-products form.
    always_comb begin
        gc[0] = cy_in;
        gc[1] = gp[0].g | (gp[0].p & cy_in);
        gc[2] = gp[1].g | (gp[1].p & gp[0].g) | (gp[1].p & gp[0].p & cy_in);
        gc[3] = gp[2].g | (gp[2].p & gp[1].g) | (gp[2].p & gp[1].p & gp[0].g)
              | (gp[2].p & gp[1].p & gp[0].p & cy_in);
        gc[4] = gp[3].g | (gp[3].p & gp[2].g) | (gp[3].p & gp[2].p & gp[1].g)
              | (gp[3].p & gp[2].p & gp[1].p & gp[0].g)
              | (gp[3].p & gp[2].p & gp[1].p & gp[0].p & cy_in);
    end

    // Result register; carry-out is loaded from the same carry as sum[16].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum    <= '0;
            cy_out <= 1'b0;
        end else begin
            sum    <= {gc[GRP_N], s_c};
            cy_out <= gc[GRP_N];
        end
    end

endmodule : bit16_adder

// File: tb/tb_bit16_adder.sv
// Directed-vector and random check of bit16_adder.
module tb_bit16_adder;

    logic        clk;
    logic        rst;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        cy_in;
    logic        cy_out;
    logic [16:0] sum;

    int checks;
    int errors;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs [10];

    bit16_adder dut (
        .clk    (clk),
        .rst    (rst),
        .in1    (in1),
        .in2    (in2),
        .cy_in  (cy_in),
        .cy_out (cy_out),
        .sum    (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                            input logic ci);
        return 17'(a) + 17'(b) + 17'(ci);
    endfunction

    // Compares sum and cy_out against an expected result; cy_out must track sum[16].
    task automatic check(input string name, input logic [16:0] exp);
        checks++;
        if (sum !== exp || cy_out !== exp[16] || cy_out !== sum[16]) begin
            errors++;
            $display("FAIL %s: sum=%05h cy_out=%0b expected sum=%05h cy_out=%0b",
                     name, sum, cy_out, exp, exp[16]);
        end
    endtask

    // Drives operands between edges, then samples 1 time unit after the next rising edge.
    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic ci);
        in1   = a;
        in2   = b;
        cy_in = ci;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
        vecs[1] = '{16'hF017, 16'hC653, 1'b0, 17'h1B66A};
        vecs[2] = '{16'hEFAC, 16'h9087, 1'b1, 17'h18034};
        vecs[3] = '{16'h3F40, 16'h567D, 1'b1, 17'h095BE};
        vecs[4] = '{16'h0777, 16'h7FFE, 1'b1, 17'h08776};
        vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, 17'h10000};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
        vecs[7] = '{16'h000F, 16'h0000, 1'b1, 17'h00010};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
        vecs[9] = '{16'h0FFF, 16'h0000, 1'b1, 17'h01000};

        // Reset asserted with nonzero operands: outputs clear with no edge.
        rst   = 1'b0;
        in1   = 16'h1234;
        in2   = 16'h4321;
        cy_in = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("reset_immediate", 17'h00000);
        @(posedge clk);
        #1;
        check("reset_held", 17'h00000);

        // Release, then first edge loads the current (zero) inputs.
        in1   = 16'h0000;
        in2   = 16'h0000;
        cy_in = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        check("first_after_release", 17'h00000);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].ci);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Back-to-back: each cycle's result appears exactly one edge later.
        apply(16'h1111, 16'h2222, 1'b0);
        check("b2b_0", 17'h03333);
        apply(16'hFFFE, 16'h0001, 1'b1);
        check("b2b_1", 17'h10000);
        apply(16'hABCD, 16'h5432, 1'b0);
        check("b2b_2", 17'h0FFFF);

        // Mid-stream reset: pending result discarded, outputs clear immediately.
        in1   = 16'hFFFF;
        in2   = 16'hFFFF;
        cy_in = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("midstream_reset", 17'h00000);
        @(posedge clk);
        #1;
        check("midstream_reset_held", 17'h00000);
        in1   = 16'h00F0;
        in2   = 16'h0F00;
        cy_in = 1'b1;
        rst   = 1'b0;
        #1;
        check("no_stale_before_edge", 17'h00000);
        @(posedge clk);
        #1;
        check("after_release_load", 17'h00FF1);

        // Random sweep against the behavioural reference.
        for (int i = 0; i < 10000; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            logic        ci;
            a  = 16'($urandom);
            b  = 16'($urandom);
            ci = 1'($urandom);
            apply(a, b, ci);
            check("random", ref_sum(a, b, ci));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bit16_adder
